// File: rtl/sipo_deser_if.sv
// Handshake/data bundle between a serial source, the deserializer and its parallel consumer.
// The master drives the serial side and the ready; the slave (the deserializer) drives results.
interface sipo_deser_if #(
  parameter int unsigned WIDTH = 4
);
  logic             sin;
  logic             sin_valid;
  logic             dir;
  logic             clear;
  logic             dout_ready;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             busy;
  logic             overrun;

  modport master (
    output sin, sin_valid, dir, clear, dout_ready,
    input  dout, dout_valid, busy, overrun
  );

  modport slave (
    input  sin, sin_valid, dir, clear, dout_ready,
    output dout, dout_valid, busy, overrun
  );
endinterface

// File: rtl/sipo_deser.sv
// Serial-in, parallel-out deserializer with per-frame bit order and a valid/ready output
// register; a word completing while the previous one is still unconsumed sets sticky overrun.
module sipo_deser #(
  parameter int unsigned WIDTH = 4
) (
  input logic         clk,
  input logic         reset,
  sipo_deser_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StRecv} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             dir_l_q, dir_l_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overrun_q, overrun_d;

  logic             shift_en;
  logic             dir_eff;
  logic [WIDTH-1:0] sr_shift;
  logic             complete;
  logic             fire;

  // Direction is taken live on the first bit of a frame, latched afterwards.
  assign shift_en = bus.sin_valid && !bus.clear;
  assign dir_eff  = (state_q == StIdle) ? bus.dir : dir_l_q;
  assign sr_shift = dir_eff ? {sr_q[WIDTH-2:0], bus.sin} : {bus.sin, sr_q[WIDTH-1:1]};
  assign complete = shift_en && (state_q == StRecv) && (cnt_q == LastCnt);
  assign fire     = dout_valid_q && bus.dout_ready;

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    dir_l_d      = dir_l_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q && !fire;
    overrun_d    = overrun_q;

    if (bus.clear) begin
      state_d = StIdle;
      sr_d    = '0;
      cnt_d   = '0;
    end else if (shift_en) begin
      sr_d = sr_shift;
      unique case (state_q)
        StIdle: begin
          dir_l_d = bus.dir;
          cnt_d   = CntW'(1);
          state_d = StRecv;
        end
        StRecv: begin
          if (complete) begin
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Load is allowed when the register is empty or being drained this very cycle.
    if (complete) begin
      if (!dout_valid_q || fire) begin
        dout_d       = sr_shift;
        dout_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      sr_q         <= '0;
      cnt_q        <= '0;
      dir_l_q      <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      dir_l_q      <= dir_l_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = (state_q == StRecv);
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser: bit order, gaps, overrun, clear and reset mid-frame,
// each against hand-computed words.
module tb_sipo_deser;

  localparam int unsigned WIDTH = 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  sipo_deser_if #(.WIDTH(WIDTH)) bus ();

  sipo_deser #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic d);
    bus.sin       = b;
    bus.dir       = d;
    bus.sin_valid = 1'b1;
    tick();
    bus.sin_valid = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w, input logic d);
    for (int i = 0; i < 4; i++) begin
      send_bit(d ? w[3-i] : w[i], d);
    end
  endtask

  task automatic drain();
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    reset          = 1'b0;
    bus.sin        = 1'b1;
    bus.sin_valid  = 1'b1;
    bus.dir        = 1'b0;
    bus.clear      = 1'b0;
    bus.dout_ready = 1'b0;

    // Reset held with activity on the serial input.
    tick();
    tick();
    check_eq("rst_dout", 32'(bus.dout), 32'h0);
    check_eq("rst_valid", 32'(bus.dout_valid), 32'h0);
    check_eq("rst_busy", 32'(bus.busy), 32'h0);
    check_eq("rst_overrun", 32'(bus.overrun), 32'h0);
    bus.sin_valid = 1'b0;
    reset         = 1'b1;
    tick();
    check_eq("post_rst_busy", 32'(bus.busy), 32'h0);

    // MSB-first, consecutive bits.
    send_bit(1'b1, 1'b1);
    check_eq("msb_busy1", 32'(bus.busy), 32'h1);
    send_bit(1'b0, 1'b1);
    check_eq("msb_busy2", 32'(bus.busy), 32'h1);
    send_bit(1'b1, 1'b1);
    check_eq("msb_busy3", 32'(bus.busy), 32'h1);
    check_eq("msb_valid_early", 32'(bus.dout_valid), 32'h0);
    send_bit(1'b1, 1'b1);
    check_eq("msb_dout", 32'(bus.dout), 32'hB);
    check_eq("msb_valid", 32'(bus.dout_valid), 32'h1);
    check_eq("msb_busy_done", 32'(bus.busy), 32'h0);
    drain();
    check_eq("drain_valid", 32'(bus.dout_valid), 32'h0);
    check_eq("drain_hold", 32'(bus.dout), 32'hB);

    // LSB-first with gaps; dir toggled mid-frame must be ignored.
    send_bit(1'b1, 1'b0);
    tick();
    send_bit(1'b0, 1'b1);
    tick();
    check_eq("lsb_gap_busy", 32'(bus.busy), 32'h1);
    send_bit(1'b1, 1'b1);
    tick();
    send_bit(1'b1, 1'b1);
    check_eq("lsb_dout", 32'(bus.dout), 32'hD);
    check_eq("lsb_valid", 32'(bus.dout_valid), 32'h1);
    drain();

    // Overrun: second word dropped, then a load coinciding with a handshake.
    send_word(4'b1011, 1'b1);
    check_eq("ovr_first", 32'(bus.dout), 32'hB);
    send_word(4'b0001, 1'b1);
    check_eq("ovr_dout_kept", 32'(bus.dout), 32'hB);
    check_eq("ovr_flag", 32'(bus.overrun), 32'h1);
    check_eq("ovr_valid", 32'(bus.dout_valid), 32'h1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    bus.dout_ready = 1'b1;
    send_bit(1'b0, 1'b1);
    bus.dout_ready = 1'b0;
    check_eq("ovr_swap_dout", 32'(bus.dout), 32'h6);
    check_eq("ovr_swap_valid", 32'(bus.dout_valid), 32'h1);
    check_eq("ovr_sticky", 32'(bus.overrun), 32'h1);
    drain();

    // Clear wins over a simultaneous bit and discards the partial frame.
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    bus.clear = 1'b1;
    send_bit(1'b1, 1'b1);
    bus.clear = 1'b0;
    check_eq("clr_busy", 32'(bus.busy), 32'h0);
    check_eq("clr_valid", 32'(bus.dout_valid), 32'h0);
    send_word(4'b0110, 1'b1);
    check_eq("clr_dout", 32'(bus.dout), 32'h6);
    check_eq("clr_valid_after", 32'(bus.dout_valid), 32'h1);
    check_eq("clr_overrun_kept", 32'(bus.overrun), 32'h1);

    // Reset mid-frame with a word pending.
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_eq("mid_rst_dout", 32'(bus.dout), 32'h0);
    check_eq("mid_rst_valid", 32'(bus.dout_valid), 32'h0);
    check_eq("mid_rst_busy", 32'(bus.busy), 32'h0);
    check_eq("mid_rst_overrun", 32'(bus.overrun), 32'h0);
    send_word(4'b1001, 1'b1);
    check_eq("mid_rst_word", 32'(bus.dout), 32'h9);
    check_eq("mid_rst_word_valid", 32'(bus.dout_valid), 32'h1);

    // Back-to-back frames with the consumer always ready.
    bus.dout_ready = 1'b1;
    send_word(4'b0011, 1'b0);
    check_eq("b2b_first", 32'(bus.dout), 32'h3);
    send_word(4'b1100, 1'b1);
    check_eq("b2b_second", 32'(bus.dout), 32'hC);
    check_eq("b2b_no_overrun", 32'(bus.overrun), 32'h0);
    bus.dout_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sipo_deser.md
# sipo_deser

Serial-in, parallel-out deserializer: the receive end of the serial stream produced by the team's universal shift register in shift-left or shift-right mode. It accumulates one bit per `sin_valid` strobe and, after WIDTH bits, presents the assembled word on a registered `dout` with a valid/ready handshake. Sits between a serial link or shift-register output and a parallel consumer. Bit order is selected per frame to match either shift direction of the transmitter.

## Interface
- `WIDTH`, default 4: word width in bits; legal range is ≥ 2.
- `clk`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  synchronous reset, active-low; sampled on `clk` rising edge.
- `sin`  in  1  serial data bit.
- `sin_valid`  in  1  `sin` is a valid bit this cycle.
- `dir`  in  1  0 = LSB-first arrival (bits enter at the MSB and shift right); 1 = MSB-first arrival (bits enter at the LSB and shift left).
- `clear`  in  1  abort the partial frame.
- `dout_ready`  in  1  consumer accepts `dout` this cycle.
- `dout`  out  WIDTH  last completed word; registered.
- `dout_valid`  out  1  `dout` holds an unconsumed word.
- `busy`  out  1  a partial frame is in progress.
- `overrun`  out  1  sticky; a completed word was dropped.

## Operation
- Internal state:
  - shift register `sr[WIDTH-1:0]`;
  - bit counter `cnt` (0..WIDTH-1);
  - latched direction `dir_l`;
  - FSM with states IDLE and RECV.
- Reset (`reset`=0 at an edge) forces `sr`=0, `cnt`=0, state IDLE, `dout`=0, `dout_valid`=0, `busy`=0, `overrun`=0. Reset overrides every other input, including mid-frame.
- IDLE:
  - With `sin_valid`=1: `dir_l`←`dir`, shift `sin` into `sr`, `cnt`←1, go to RECV.
  - Exception, WIDTH=1: not supported.
- RECV:
  - Each `sin_valid`=1 shifts `sin` in using `dir_l`.
    - `dir_l`=0: `sr`←{`sin`, `sr[WIDTH-1:1]`}.
    - `dir_l`=1: `sr`←{`sr[WIDTH-2:0]`, `sin`}.
  - `cnt` increments on each shifted bit.
  - `dir` changes mid-frame are ignored.
  - `sin_valid`=0 holds all state; gaps of any length are allowed.
- Completion: the WIDTH-th bit is accepted with `cnt`=WIDTH-1. The assembled word (`sr` including that bit) is offered to the output register, then `cnt`←0 and the FSM returns to IDLE.
- Output register:
  - Handshake fires when `dout_valid`=1 and `dout_ready`=1; `dout_valid` then clears unless a new word loads in the same cycle.
  - At completion, the word loads into `dout` and `dout_valid`←1 if `dout_valid`=0, or if the handshake fires in the same cycle.
  - Otherwise the new word is dropped, `dout` is unchanged, and `overrun`←1.
  - `overrun` clears only on reset.
- `clear`=1:
  - Sets `sr`=0, `cnt`=0 and returns the FSM to IDLE.
  - Any `sin_valid` in the same cycle is discarded (`clear` wins).
  - Does not affect `dout`, `dout_valid` or `overrun`.
  - A handshake in the same cycle still completes.
- `busy` = (state == RECV), registered.

## Timing
- All outputs are registered and change only on `clk` rising edges.
- Latency: the last bit is sampled at edge k; `dout` and `dout_valid` are updated at that same edge k and visible in cycle k+1. There is no extra pipeline stage.
- Throughput: one bit per cycle. Back-to-back frames need no idle cycle; bit 0 of the next frame may arrive in the cycle after completion.
- `dout_ready` is ignored while `dout_valid`=0.
- `dout` holds its value after a handshake until the next load; consumers qualify it with `dout_valid`.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles with `sin_valid`=1, `sin`=1 → `dout`=0, `dout_valid`=0, `busy`=0, `overrun`=0; no bits counted after release.
- **MSB-first:** `dir`=1, bits 1,0,1,1 on 4 consecutive cycles, `dout_ready`=0 → `busy`=1 after bits 1–3, then `dout`=4'b1011, `dout_valid`=1, `busy`=0.
- **LSB-first with gaps:** `dir`=0, bits 1,0,1,1 with one idle cycle between each bit; toggle `dir` after the first bit → `dout`=4'b1101.
- **Overrun:**
  - Word 4'b1011, then word 4'b0001 (`dir`=1) with `dout_ready`=0 → `dout` stays 4'b1011, `overrun`=1.
  - Then with `dout_ready`=1 in the completion cycle of word 4'b0110 → `dout`=4'b0110, `dout_valid`=1, `overrun` remains 1.
- **Clear:**
  - `dir`=1, bits 1,1, then `clear`=1 together with `sin_valid`=1 → `busy`=0.
  - Then bits 0,1,1,0 → `dout`=4'b0110, `dout_valid`=1.
- **Reset mid-frame:** after 3 bits, assert `reset`=0 for one cycle with `dout_valid`=1 → all outputs 0; the next 4 bits 1,0,0,1 (`dir`=1) yield `dout`=4'b1001.
